// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encodings, common command bytes and frame size.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock/data pads with a 2-sample stability
// filter; fall/rise are single-cycle pulses of the filtered clock.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_pad,
  input  logic dat_pad,
  output logic clk_s,
  output logic dat_s,
  output logic fall,
  output logic rise
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized sample
  logic [2:0] clk_sh;
  logic [2:0] dat_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sh <= 3'b111;
      dat_sh <= 3'b111;
      clk_s  <= 1'b1;
      dat_s  <= 1'b1;
      fall   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      clk_sh <= {clk_sh[1:0], clk_pad};
      dat_sh <= {dat_sh[1:0], dat_pad};
      fall   <= 1'b0;
      rise   <= 1'b0;
      // single-cycle glitches never see two equal samples and are dropped
      if (clk_sh[2] == clk_sh[1]) begin
        clk_s <= clk_sh[1];
        fall  <= clk_s & ~clk_sh[1];
        rise  <= ~clk_s & clk_sh[1];
      end
      if (dat_sh[2] == dat_sh[1]) begin
        dat_s <= dat_sh[1];
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter driving open-drain clock/data via output enables.
// Build option: define PS2_HOST_TX_RETRY_EN to re-run a failed frame once before tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 1600,
  parameter int TIMEOUT_CYC = 32000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [2:0] state_dbg
);

  // Handshake: a request is taken on any cycle with tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid while busy has no effect.

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  // INHIBIT ends one cycle early because REQ keeps the clock low for one more
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] TO_LAST  =
    CNT_W'((TIMEOUT_CYC - 1 > CNT_MAX) ? CNT_MAX : TIMEOUT_CYC - 1);
  localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 2);
  localparam logic [3:0] PARITY_IDX = 4'(FRAME_BITS - 3);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_step;
  logic [7:0]       data_q;
  logic             par_q;
  logic [3:0]       bit_idx;
  logic             clk_s, dat_s, fall, rise;
  logic             line_phase, nack, timeout, fail;
`ifdef PS2_HOST_TX_RETRY_EN
  logic             retried;
`endif

  ps2_line_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .clk_pad (ps2_clk_in),
    .dat_pad (ps2_dat_in),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .fall    (fall),
    .rise    (rise)
  );

  always_comb begin
    line_phase = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    cnt_step   = (&cnt) ? cnt : cnt + 1'b1;
    nack       = (state == ST_ACK) && fall && dat_s;
    timeout    = line_phase && !(fall || rise) && (cnt >= TO_LAST);
    fail       = nack || timeout;
  end

  assign tx_ready  = (state == ST_IDLE);
  assign tx_busy   = ~tx_ready;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      bit_idx    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retried    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (fail) begin
        ps2_dat_oe <= 1'b0;
        cnt        <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
        if (!retried) begin
          retried    <= 1'b1;
          ps2_clk_oe <= 1'b1;
          state      <= ST_INHIBIT;
        end else begin
          ps2_clk_oe <= 1'b0;
          tx_err     <= 1'b1;
          state      <= ST_IDLE;
        end
`else
        ps2_clk_oe <= 1'b0;
        tx_err     <= 1'b1;
        state      <= ST_IDLE;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_valid) begin
              data_q     <= tx_data;
              par_q      <= odd_parity(tx_data);
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              cnt        <= '0;
              state      <= ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
              retried    <= 1'b0;
`endif
            end
          end
          ST_INHIBIT: begin
            if (cnt == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              state      <= ST_REQ;
            end else begin
              cnt <= cnt_step;
            end
          end
          ST_REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            cnt        <= '0;
            state      <= ST_SHIFT;
          end
          ST_SHIFT: begin
            cnt <= (fall || rise) ? '0 : cnt_step;
            if (fall) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == STOP_IDX) begin
                ps2_dat_oe <= 1'b0;
                state      <= ST_ACK;
              end else if (bit_idx == PARITY_IDX) begin
                ps2_dat_oe <= ~par_q;
              end else begin
                ps2_dat_oe <= ~data_q[bit_idx[2:0]];
              end
            end
          end
          ST_ACK: begin
            cnt <= (fall || rise) ? '0 : cnt_step;
            if (fall) state <= ST_WAIT_IDLE;
          end
          ST_WAIT_IDLE: begin
            cnt <= (fall || rise) ? '0 : cnt_step;
            if (clk_s && dat_s) begin
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// sampled bits and done/err outcomes are checked against expected queues.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 20;
  localparam int INH  = 1600;
  localparam int TMO  = 32000;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 2;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, tx_busy;
  logic       ps2_clk_oe, ps2_dat_oe, ps2_clk_in, ps2_dat_in;
  logic [2:0] state_dbg;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // open-drain wired-AND of host and device
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .tx_busy    (tx_busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .state_dbg  (state_dbg)
  );

  // scoreboard
  logic [0:0] exp_q[$];   // expected line bits at device rising edges
  logic [1:0] res_q[$];   // expected {tx_done, tx_err} outcome per request
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, done_cnt = 0, both_cnt = 0, busy_bad = 0;
  int oe_run = 0, last_inhibit = 0, rel_cyc = 0, err_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    cyc++;
    if (tx_done && tx_err) both_cnt++;
    if (tx_busy !== ~tx_ready) busy_bad++;
    if (ps2_clk_oe === 1'b1) oe_run++;
    else begin
      if (oe_run != 0) begin
        last_inhibit = oe_run;
        rel_cyc = cyc;
      end
      oe_run = 0;
    end
    if (tx_done) done_cnt++;
    if (tx_done || tx_err) begin
      if (tx_err) err_cyc = cyc;
      if (res_q.size() == 0) check("unexpected_result", {30'd0, tx_done, tx_err}, 32'd0);
      else begin
        e = res_q.pop_front();
        check("result", {30'd0, tx_done, tx_err}, {30'd0, e});
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       nack;
    logic       spam;
    int         glitch;
    logic [1:0] res;
  } vec_t;
  vec_t vecs[6];

  // driver tasks
  task automatic push_bits(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic spam);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (spam) begin
      tx_data = 8'h55;
      tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check("ready_while_busy", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
      end
      tx_valid = 1'b0;
    end
  endtask

  task automatic dev_wait_req(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_frame(input logic nack, input int glitch);
    logic [0:0] b, e;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      b = ps2_dat_in;
      if (exp_q.size() == 0) check("bit_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check($sformatf("frame_bit%0d", i), {31'd0, b}, {31'd0, e});
      end
      if (i == glitch) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat_low = ~nack;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_results(input int budget);
    int n = 0;
    while (res_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("result_in_time", res_q.size(), 32'd0);
    res_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int attempts, d0;
    logic ok;
    attempts = v.nack ? FAIL_ATTEMPTS : 1;
    d0 = done_cnt;
    res_q.push_back(v.res);
    send(v.data, v.spam);
    for (int a = 0; a < attempts; a++) begin
      push_bits(v.data, v.par);
      dev_wait_req(ok);
      check("request_seen", {31'd0, ok}, 32'd1);
      if (!ok) begin
        exp_q.delete();
        break;
      end
      dev_frame(v.nack, v.glitch);
      check("inhibit_len", last_inhibit, INH);
    end
    wait_results(500);
    repeat (5) @(negedge clk);
    check("done_count", done_cnt - d0, {31'd0, v.res[1]});
  endtask

  initial begin
    logic ok;
    logic [7:0] rnd;
    int diff;
    rnd = 8'($urandom_range(0, 255));
    vecs[0] = '{CMD_SET_LED, 1'b1, 1'b0, 1'b0, -1, 2'b10};
    vecs[1] = '{8'h01,       1'b0, 1'b0, 1'b1, -1, 2'b10};
    vecs[2] = '{CMD_RESET,   1'b1, 1'b0, 1'b0, -1, 2'b10};
    vecs[3] = '{CMD_ENABLE,  1'b0, 1'b1, 1'b0, -1, 2'b01};
    vecs[4] = '{8'h5A,       1'b1, 1'b0, 1'b0,  3, 2'b10};
    vecs[5] = '{rnd,         ~^rnd, 1'b0, 1'b0, -1, 2'b10};

    repeat (3) @(negedge clk);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // device never clocks: timeout measured from clock release
    res_q.push_back(2'b01);
    send(8'hAB, 1'b0);
    wait_results(FAIL_ATTEMPTS * (TMO + INH + 100) + 100);
    diff = err_cyc - rel_cyc;
    n_cmp++;
    if (diff < TMO || diff > TMO + 8) begin
      n_bad++;
      $display("FAIL timeout_interval: got %0d expected %0d..%0d", diff, TMO, TMO + 8);
    end
    check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("timeout_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // reset after the 4th device clock fall (0xF4 bit3 = 0, so data is pulled low)
    send(CMD_ENABLE, 1'b0);
    dev_wait_req(ok);
    check("rst_test_req", {31'd0, ok}, 32'd1);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < 3) begin
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    check("dat_oe_before_reset", {31'd0, ps2_dat_oe}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("async_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    @(negedge clk);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);
    dev_clk_low = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    run_vec(vecs[0]);

    // reset while inhibiting releases the clock line at once
    send(8'h12, 1'b0);
    repeat (100) @(negedge clk);
    check("inhibit_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    reset = 1'b1;
    #1;
    check("inhibit_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check("busy_vs_ready", busy_bad, 32'd0);
    check("done_err_overlap", both_cnt, 32'd0);
    check("bits_left", exp_q.size(), 32'd0);
    check("results_left", res_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_300_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes to the keyboard on the shared ps2_clk/ps2_dat lines, e.g. LED set 0xED or reset 0xFF.
- It is the opposite direction of the existing keyboard receive path. It sits beside the PS/2 receiver inside the system bus peripheral set.
- It drives the lines open-drain through output-enable signals; the top level owns the tristate pads.
- It reports done or error to the CPU-side register interface.

Parameters:
- INHIBIT_CYC, 1600: cycles the clock line is held low before the request (100 us at 16 MHz).
- TIMEOUT_CYC, 32000: maximum cycles between device clock edges, and from request to first edge (2 ms).
- CNT_W, 16: width of the shared inhibit/timeout counter.

Ports:
- clk  in  1  system clock, 16 MHz
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  send request, qualified by tx_ready
- tx_ready  out  1  idle, accepting a request
- tx_done  out  1  one-cycle pulse: frame acknowledged by the device
- tx_err  out  1  one-cycle pulse: NACK or timeout
- tx_busy  out  1  high from request acceptance until done/err; the receiver ignores frames while this is high
- ps2_clk_in  in  1  raw clock pad input (asynchronous)
- ps2_dat_in  in  1  raw data pad input (asynchronous)
- ps2_clk_oe  out  1  1 = pull clock low
- ps2_dat_oe  out  1  1 = pull data low

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0, state IDLE.
- Asynchronous reset mid-frame releases both lines immediately.
- Pad inputs pass through a 2-flop synchronizer. fall/rise are single-cycle pulses derived from the synchronized clock.
- Handshake: a transfer is accepted on the cycle where tx_valid && tx_ready. That cycle latches tx_data and the odd parity, ~^tx_data. tx_valid while busy is ignored.
- States:
  - IDLE: tx_ready=1. On acceptance → INHIBIT, with clk_oe=1 and counter cleared.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles. On the last cycle set dat_oe=1 (start bit) → REQ.
  - REQ: hold clk_oe=1 and dat_oe=1 for 1 cycle, then clk_oe=0 → SHIFT, with bit index 0 and counter cleared.
  - SHIFT: on each fall, drive the next bit, with dat_oe = ~bit.
    - Falls 1–8 drive data[0..7], LSB first.
    - Fall 9 drives parity.
    - Fall 10 sets dat_oe=0 (stop bit, released) → ACK.
  - ACK: on the next fall, sample synchronized data. 0 → WAIT_IDLE; 1 → error.
  - WAIT_IDLE: wait until synchronized clk=1 and dat=1, then pulse tx_done → IDLE.
- Timeout:
  - The counter clears on every fall/rise in REQ/SHIFT/ACK/WAIT_IDLE.
  - Reaching TIMEOUT_CYC releases both lines, pulses tx_err and returns to IDLE.
- Error path: release both lines, pulse tx_err for 1 cycle, → IDLE with tx_ready=1 on the following cycle.
- tx_busy = ~tx_ready. tx_done and tx_err are never high in the same cycle.
- The counter saturates and does not wrap, which is required when CNT_W is small.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, the block re-runs the frame from INHIBIT exactly once, without pulsing tx_err.
  - tx_err pulses only if the retry also fails.
  - tx_busy stays high throughout.
- Undefined: the first failure pulses tx_err. No retry state or retry flag is synthesized.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding constants (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - PS/2 command constants (0xED, 0xFF, 0xF4);
  - the frame bit-count constant, 11.
- Sub-module ps2_line_sync: 2-flop synchronizer for clk/dat plus fall/rise pulse generation. The existing receiver reuses it.

Test Plan:
- Send 0xED with a device model that acks:
  - clk_oe is low-asserted for exactly 1600 cycles;
  - data bits sampled on the device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - ack is seen, and tx_done pulses once.
- Send 0x01 and then 0xFF back-to-back: parities 0 and 1; the second tx_valid is ignored until tx_ready returns.
- Device never clocks after the request: tx_err pulses 32000 cycles after clk_oe release, and both oe are 0.
- Device returns ack=1 (NACK) on 0xF4: tx_err pulses and tx_done stays 0. With PS2_HOST_TX_RETRY_EN, a second frame appears, and a NACK on it is required before tx_err pulses.
- Assert reset after the 4th fall of a frame: same cycle ps2_clk_oe=ps2_dat_oe=0, then tx_ready=1. A following 0xED send completes normally.
- Device clock glitch shorter than 2 cycles: no bit advance, and the frame still completes correctly.
